// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with a valid/ready handshake
// and a MULT/DIV busy sequencer that holds off new requests until the HI/LO
// unit finishes.
// Optional feature macro: ALU_CTRL_SHIFT_EN adds SLL/SRL/SRA R-type decodes.
module alu_ctrl_seq #(
  parameter int unsigned ALUOP_W   = 3,
  parameter int unsigned CTL_W     = 4,
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  input  logic               stall_in,
  input  logic               flush,
  output logic               out_valid,
  output logic [CTL_W-1:0]   alu_ctl,
  output logic               illegal,
  output logic               md_start,
  output logic               md_op,
  output logic               md_busy,
  output logic               md_done
);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q;
  logic [CTL_W-1:0] alu_ctl_q;
  logic             illegal_q;
  logic             md_start_q;
  logic             md_op_q;

  logic [3:0]       dec_ctl;
  logic             dec_ill;
  logic             dec_md;
  logic             dec_mdop;
  logic             accept;

  // Decode the op class and R-type funct; anything unrecognised is flagged.
  always_comb begin
    dec_ctl  = 4'b1111;
    dec_ill  = 1'b1;
    dec_md   = 1'b0;
    dec_mdop = 1'b0;
    case (alu_op)
      ALUOP_W'(0): begin
        dec_ill = 1'b0;
        case (funct)
          6'b100000, 6'b100001: dec_ctl = 4'b0010;
          6'b100010, 6'b100011: dec_ctl = 4'b0110;
          6'b100100:            dec_ctl = 4'b0000;
          6'b100101:            dec_ctl = 4'b0001;
          6'b100110:            dec_ctl = 4'b0011;
          6'b100111:            dec_ctl = 4'b1100;
          6'b101010:            dec_ctl = 4'b0111;
          6'b011000: begin
            dec_ctl = 4'b1110;
            dec_md  = 1'b1;
          end
          6'b011010: begin
            dec_ctl  = 4'b1110;
            dec_md   = 1'b1;
            dec_mdop = 1'b1;
          end
`ifdef ALU_CTRL_SHIFT_EN
          6'b000000:            dec_ctl = 4'b1000;
          6'b000010:            dec_ctl = 4'b1001;
          6'b000011:            dec_ctl = 4'b1011;
`endif
          default: begin
            dec_ctl = 4'b1111;
            dec_ill = 1'b1;
          end
        endcase
      end
      ALUOP_W'(1): begin dec_ctl = 4'b0010; dec_ill = 1'b0; end
      ALUOP_W'(2): begin dec_ctl = 4'b0110; dec_ill = 1'b0; end
      ALUOP_W'(3): begin dec_ctl = 4'b0000; dec_ill = 1'b0; end
      ALUOP_W'(4): begin dec_ctl = 4'b0001; dec_ill = 1'b0; end
      ALUOP_W'(5): begin dec_ctl = 4'b0111; dec_ill = 1'b0; end
      ALUOP_W'(6): begin dec_ctl = 4'b1010; dec_ill = 1'b0; end
      default: begin
        dec_ctl = 4'b1111;
        dec_ill = 1'b1;
      end
    endcase
  end

  // Handshake: blocked while the sequencer runs, while a stalled result is held, or on flush.
  always_comb begin
    in_ready = (state_q != StBusy) && !(out_valid_q && stall_in) && !flush;
    accept   = in_valid && in_ready;
  end

  // Output register: flush clears, accept loads, stall holds, otherwise valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_ctl_q   <= '0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
        illegal_q   <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        alu_ctl_q   <= CTL_W'(dec_ctl);
        illegal_q   <= dec_ill;
      end else if (!stall_in) begin
        out_valid_q <= 1'b0;
      end
      md_start_q <= accept && dec_md;
      if (accept && dec_md) begin
        md_op_q <= dec_mdop;
      end
    end
  end

  // Sequencer state register and down-counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state: countdown is independent of downstream stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && dec_md) begin
            state_d = StBusy;
            cnt_d   = CNT_W'(MD_CYCLES - 1);
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sequencer outputs: done marks the last busy cycle unless it is being flushed.
  always_comb begin
    md_busy = (state_q == StBusy);
    md_done = (state_q == StBusy) && (cnt_q == '0) && !flush;
  end

  assign out_valid = out_valid_q;
  assign alu_ctl   = alu_ctl_q;
  assign illegal   = illegal_q;
  assign md_start  = md_start_q;
  assign md_op     = md_op_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with MD_CYCLES=4.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       stall_in;
  logic       flush;
  logic       out_valid;
  logic [3:0] alu_ctl;
  logic       illegal;
  logic       md_start;
  logic       md_op;
  logic       md_busy;
  logic       md_done;

  int checks = 0;
  int errors = 0;

  alu_ctrl_seq #(
    .ALUOP_W  (3),
    .CTL_W    (4),
    .MD_CYCLES(4),
    .CNT_W    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .funct    (funct),
    .stall_in (stall_in),
    .flush    (flush),
    .out_valid(out_valid),
    .alu_ctl  (alu_ctl),
    .illegal  (illegal),
    .md_start (md_start),
    .md_op    (md_op),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] v_op   [9];
  logic [5:0] v_fn   [9];
  logic [3:0] v_ctl  [9];
  logic       v_ill  [9];

  initial begin
    v_op[0] = 3'd3; v_fn[0] = 6'b000000; v_ctl[0] = 4'b0000; v_ill[0] = 1'b0;
    v_op[1] = 3'd4; v_fn[1] = 6'b000000; v_ctl[1] = 4'b0001; v_ill[1] = 1'b0;
    v_op[2] = 3'd5; v_fn[2] = 6'b000000; v_ctl[2] = 4'b0111; v_ill[2] = 1'b0;
    v_op[3] = 3'd6; v_fn[3] = 6'b000000; v_ctl[3] = 4'b1010; v_ill[3] = 1'b0;
    v_op[4] = 3'd0; v_fn[4] = 6'b100110; v_ctl[4] = 4'b0011; v_ill[4] = 1'b0;
    v_op[5] = 3'd0; v_fn[5] = 6'b100111; v_ctl[5] = 4'b1100; v_ill[5] = 1'b0;
    v_op[6] = 3'd0; v_fn[6] = 6'b100001; v_ctl[6] = 4'b0010; v_ill[6] = 1'b0;
`ifdef ALU_CTRL_SHIFT_EN
    v_op[7] = 3'd0; v_fn[7] = 6'b000000; v_ctl[7] = 4'b1000; v_ill[7] = 1'b0;
    v_op[8] = 3'd0; v_fn[8] = 6'b000011; v_ctl[8] = 4'b1011; v_ill[8] = 1'b0;
`else
    v_op[7] = 3'd0; v_fn[7] = 6'b000000; v_ctl[7] = 4'b1111; v_ill[7] = 1'b1;
    v_op[8] = 3'd0; v_fn[8] = 6'b000011; v_ctl[8] = 4'b1111; v_ill[8] = 1'b1;
`endif

    rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; funct = '0; stall_in = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_ctl",   32'(alu_ctl),   32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_md_start",  32'(md_start),  32'd0);
    chk("rst_md_op",     32'(md_op),     32'd0);
    chk("rst_md_busy",   32'(md_busy),   32'd0);
    chk("rst_md_done",   32'(md_done),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // SUB via R-type funct
    alu_op = 3'd0; funct = 6'b100010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sub_valid",   32'(out_valid), 32'd1);
    chk("sub_ctl",     32'(alu_ctl),   32'h6);
    chk("sub_illegal", 32'(illegal),   32'd0);
    tick();
    chk("sub_clear",   32'(out_valid), 32'd0);

    // Illegal funct, then illegal op class
    funct = 6'b101111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ill_fn_valid", 32'(out_valid), 32'd1);
    chk("ill_fn_ctl",   32'(alu_ctl),   32'hF);
    chk("ill_fn_flag",  32'(illegal),   32'd1);
    chk("ill_fn_start", 32'(md_start),  32'd0);
    tick();
    chk("ill_fn_busy",  32'(md_busy),   32'd0);
    alu_op = 3'd7; funct = 6'b011000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ill_op_ctl",   32'(alu_ctl),   32'hF);
    chk("ill_op_flag",  32'(illegal),   32'd1);
    chk("ill_op_start", 32'(md_start),  32'd0);
    tick();
    chk("ill_op_busy",  32'(md_busy),   32'd0);

    // Back-to-back decode table
    for (int i = 0; i < 9; i++) begin
      alu_op = v_op[i]; funct = v_fn[i]; in_valid = 1'b1;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_ctl", i),   32'(alu_ctl),   32'(v_ctl[i]));
      chk($sformatf("tbl%0d_ill", i),   32'(illegal),   32'(v_ill[i]));
    end
    in_valid = 1'b0;
    tick();

    // MULT, with a DIV held on in_valid during the busy window
    alu_op = 3'd0; funct = 6'b011000; in_valid = 1'b1;
    tick();
    funct = 6'b011010;
    #1;
    chk("mul_c1_start", 32'(md_start), 32'd1);
    chk("mul_c1_op",    32'(md_op),    32'd0);
    chk("mul_c1_ctl",   32'(alu_ctl),  32'hE);
    chk("mul_c1_busy",  32'(md_busy),  32'd1);
    chk("mul_c1_done",  32'(md_done),  32'd0);
    chk("mul_c1_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mul_c2_start", 32'(md_start), 32'd0);
    chk("mul_c2_busy",  32'(md_busy),  32'd1);
    chk("mul_c2_done",  32'(md_done),  32'd0);
    chk("mul_c2_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mul_c3_busy",  32'(md_busy),  32'd1);
    chk("mul_c3_done",  32'(md_done),  32'd0);
    tick();
    chk("mul_c4_busy",  32'(md_busy),  32'd1);
    chk("mul_c4_done",  32'(md_done),  32'd1);
    chk("mul_c4_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mul_c5_busy",  32'(md_busy),  32'd0);
    chk("mul_c5_done",  32'(md_done),  32'd0);
    chk("mul_c5_ready", 32'(in_ready), 32'd1);
    chk("mul_c5_nostart", 32'(md_start), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("div_start", 32'(md_start), 32'd1);
    chk("div_op",    32'(md_op),    32'd1);
    chk("div_busy",  32'(md_busy),  32'd1);
    tick(); tick(); tick();
    chk("div_done",  32'(md_done),  32'd1);
    tick();
    chk("div_idle",  32'(md_busy),  32'd0);

    // Downstream stall holds the ADD result and blocks new requests
    alu_op = 3'd1; in_valid = 1'b1;
    tick();
    stall_in = 1'b1; alu_op = 3'd2;
    #1;
    chk("stall_ready0", 32'(in_ready),  32'd0);
    chk("stall_valid0", 32'(out_valid), 32'd1);
    chk("stall_ctl0",   32'(alu_ctl),   32'h2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall_ctl%0d", i),   32'(alu_ctl),   32'h2);
      chk($sformatf("stall_ready%0d", i), 32'(in_ready),  32'd0);
    end
    stall_in = 1'b0; in_valid = 1'b0;
    tick();
    chk("stall_release", 32'(out_valid), 32'd0);

    // DIV flushed on busy cycle 2; an ADD presented with the flush is dropped
    alu_op = 3'd0; funct = 6'b011010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; alu_op = 3'd1; in_valid = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    chk("flush_done0", 32'(md_done),  32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy",  32'(md_busy),   32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_done1", 32'(md_done),   32'd0);
    tick(); tick(); tick();
    chk("flush_done2", 32'(md_done),   32'd0);
    chk("flush_ready2", 32'(in_ready), 32'd1);

    // Reset mid-sequence aborts the MULT
    alu_op = 3'd0; funct = 6'b011000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_busy",  32'(md_busy),   32'd0);
    chk("rstmid_done",  32'(md_done),   32'd0);
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_start", 32'(md_start),  32'd0);
    tick(); tick(); tick();
    chk("rstmid_done2", 32'(md_done),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes ALU-op class plus R-type funct into an ALU control word, with a valid/ready handshake at the ID/EX boundary.
- Adds a multi-cycle sequencer for MULT/DIV that holds off new instructions until the HI/LO unit finishes.
- Unknown encodings are flagged explicitly; they never hold a stale output.

Parameters:
- ALUOP_W, 3, width of alu_op class input.
- CTL_W, 4, width of alu_ctl output (must be at least 4).
- MD_CYCLES, 32, busy cycles for MULT/DIV (legal range 1..255).
- CNT_W, 8, width of the MULT/DIV down-counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  decode request valid
- in_ready  out  1  block can accept a request this cycle
- alu_op  in  ALUOP_W  op class from main control
- funct  in  6  instruction[5:0]
- stall_in  in  1  downstream hold; output register frozen
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  alu_ctl/illegal valid
- alu_ctl  out  CTL_W  ALU control word
- illegal  out  1  unsupported alu_op/funct combination
- md_start  out  1  one-cycle start pulse to the HI/LO unit
- md_op  out  1  0=MULT, 1=DIV (valid with md_start)
- md_busy  out  1  MULT/DIV sequence in progress
- md_done  out  1  one-cycle pulse on last busy cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, alu_ctl=0, illegal=0, md_start=0, md_op=0, md_busy=0, md_done=0, counter=0.
- in_ready = !md_busy && !(out_valid && stall_in) && !flush.
- Accept happens on a clk edge with in_valid && in_ready. Outputs are registered with one-cycle latency: out_valid=1 with the decoded word in the following cycle.
- A cycle with out_valid=1, stall_in=0 and no new accept clears out_valid. While stall_in=1, alu_ctl, illegal and out_valid hold.
- alu_op decode: 000=R-type via funct; 001=ADD 0010; 010=SUB 0110; 011=AND 0000; 100=OR 0001; 101=SLT 0111; 110=LUI 1010; 111=illegal.
- funct decode (R-type):
  - 100000/100001 → 0010
  - 100010/100011 → 0110
  - 100100 → 0000
  - 100101 → 0001
  - 100110 → 0011
  - 100111 → 1100
  - 101010 → 0111
  - 011000 MULT → 1110, md_op=0
  - 011010 DIV → 1110, md_op=1
- Any other funct, or alu_op=111: alu_ctl=1111, illegal=1, out_valid=1. Illegal never starts the sequencer.
- Bits above bit 3 of alu_ctl are zero-extended when CTL_W>4.
- MULT/DIV accept, in the next cycle: md_start=1 (single cycle), md_busy=1, counter=MD_CYCLES-1.
- Each busy cycle decrements the counter. md_done=1 in the busy cycle where counter==0; md_busy drops the following cycle, and in_ready may then rise.
- MD_CYCLES=1: md_start, md_busy and md_done are all high in the same single cycle.
- flush=1 has priority over everything except reset. It clears out_valid, illegal, md_busy and counter, and issues no md_done. A request presented the same cycle is dropped, since in_ready=0.
- stall_in does not pause the counter; the MULT/DIV countdown runs independently of downstream hold.
- Reset or flush mid-sequence aborts it without an md_done pulse.

Optional Feature:
- Macro ALU_CTRL_SHIFT_EN.
- Defined: funct 000000 SLL → 1000, 000010 SRL → 1001, 000011 SRA → 1011. SLL with funct 000000 is a legal decode, so NOP decodes as SLL.
- Undefined: those functs decode as illegal (alu_ctl=1111, illegal=1).

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 → all outputs 0, in_ready=1.
- alu_op=000, funct=100010, in_valid=1 one cycle → next cycle out_valid=1, alu_ctl=0110, illegal=0; the following cycle out_valid=0.
- funct=101111 (R-type) → alu_ctl=1111, illegal=1, md_start never asserts. Then alu_op=111 → same.
- MULT with MD_CYCLES=4 → md_start for 1 cycle, md_busy for 4 cycles, md_done on the 4th, in_ready=0 throughout and 1 the cycle after. A DIV held on in_valid meanwhile is accepted only then, with md_op=1.
- stall_in=1 for 3 cycles after an ADD (alu_op=001) → alu_ctl=0010 and out_valid held, in_ready=0. Release → clears next cycle.
- DIV accepted, flush on busy cycle 2 → md_busy=0 next cycle, no md_done, out_valid=0. Also assert rst_n=0 mid-sequence → same abort.
